// File: rtl/game_pkg.sv
// Shared encodings for the match state: phases, characters, winners and the
// bit layout of the packed data word consumed by game_character_health.
package game_pkg;

  typedef enum logic [1:0] {
    PH_SELECT = 2'b00,
    PH_FIGHT  = 2'b01,
    PH_OVER   = 2'b10
  } phase_e;

  typedef enum logic [1:0] {
    MAGE     = 2'b00,
    GUNMAN   = 2'b01,
    SWORDMAN = 2'b10,
    FISTMAN  = 2'b11
  } char_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  localparam int DATA_W        = 12;
  localparam int HEALTH_W      = 4;
  localparam int CHAR_W        = 2;
  localparam int P2_HEALTH_LSB = 0;
  localparam int P2_CHAR_LSB   = 4;
  localparam int P1_HEALTH_LSB = 6;
  localparam int P1_CHAR_LSB   = 10;

  // Health never wraps: damage larger than the remaining health lands on 0.
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] health,
                                                  input logic [1:0]          dmg);
    logic [HEALTH_W-1:0] dmg_ext;
    dmg_ext = {2'b00, dmg};
    return (health > dmg_ext) ? (health - dmg_ext) : '0;
  endfunction

  function automatic logic [DATA_W-1:0] pack_data(input char_e               p1_char,
                                                  input logic [HEALTH_W-1:0] p1_health,
                                                  input char_e               p2_char,
                                                  input logic [HEALTH_W-1:0] p2_health);
    logic [DATA_W-1:0] word;
    word = '0;
    word[P1_CHAR_LSB   +: CHAR_W]   = p1_char;
    word[P1_HEALTH_LSB +: HEALTH_W] = p1_health;
    word[P2_CHAR_LSB   +: CHAR_W]   = p2_char;
    word[P2_HEALTH_LSB +: HEALTH_W] = p2_health;
    return word;
  endfunction

endpackage

// File: rtl/player_health_unit.sv
// One player's health register and hit cooldown. Hits are only considered
// while fight is high; restore puts the player back to a fresh-match state.
module player_health_unit
  import game_pkg::*;
#(
  parameter int MAX_HEALTH      = 10,
  parameter int COOLDOWN_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fight,
  input  logic                restore,
  input  logic                hit,
  input  logic [1:0]          dmg,
  output logic [HEALTH_W-1:0] health,
  output logic                zero_next
);

  localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 1);

  logic [HEALTH_W-1:0] health_q, health_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;

  // Loading COOLDOWN_CYCLES at the accept edge k keeps the counter nonzero
  // through edge k+COOLDOWN_CYCLES, so the next hit lands at k+COOLDOWN_CYCLES+1.
  always_comb begin
    accept   = fight && hit && (dmg != 2'b00) && (cnt_q == '0);
    health_d = health_q;
    cnt_d    = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
    if (restore) begin
      health_d = HEALTH_W'(MAX_HEALTH);
      cnt_d    = '0;
    end else if (accept) begin
      health_d = sat_sub(health_q, dmg);
      cnt_d    = CNT_W'(COOLDOWN_CYCLES);
    end
    zero_next = fight && (health_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      health_q <= HEALTH_W'(MAX_HEALTH);
      cnt_q    <= '0;
    end else begin
      health_q <= health_d;
      cnt_q    <= cnt_d;
    end
  end

  assign health = health_q;

endmodule

// File: rtl/game_state_tracker.sv
// Per-match state for two players: phase FSM, character latches, winner and
// the packed data word; health and cooldown live in player_health_unit.
module game_state_tracker
  import game_pkg::*;
#(
  parameter int MAX_HEALTH      = 10,
  parameter int COOLDOWN_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        p1_char_sel,
  input  logic [1:0]        p2_char_sel,
  input  logic              p1_hit,
  input  logic              p2_hit,
  input  logic [1:0]        p1_dmg,
  input  logic [1:0]        p2_dmg,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        phase,
  output logic [1:0]        winner
);

  phase_e  phase_q, phase_d;
  winner_e winner_q, winner_d;
  char_e   p1_char_q, p1_char_d;
  char_e   p2_char_q, p2_char_d;

  logic                fight;
  logic                restore;
  logic                rematch;
  logic                p1_zero_next, p2_zero_next;
  logic [HEALTH_W-1:0] p1_health, p2_health;

  assign fight   = (phase_q == PH_FIGHT);
  assign restore = (phase_q == PH_SELECT) || rematch;

  player_health_unit #(
    .MAX_HEALTH      (MAX_HEALTH),
    .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
  ) u_p1 (
    .clk       (clk),
    .reset     (reset),
    .fight     (fight),
    .restore   (restore),
    .hit       (p1_hit),
    .dmg       (p1_dmg),
    .health    (p1_health),
    .zero_next (p1_zero_next)
  );

  player_health_unit #(
    .MAX_HEALTH      (MAX_HEALTH),
    .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
  ) u_p2 (
    .clk       (clk),
    .reset     (reset),
    .fight     (fight),
    .restore   (restore),
    .hit       (p2_hit),
    .dmg       (p2_dmg),
    .health    (p2_health),
    .zero_next (p2_zero_next)
  );

  always_comb begin
    phase_d   = phase_q;
    winner_d  = winner_q;
    p1_char_d = p1_char_q;
    p2_char_d = p2_char_q;
    rematch   = 1'b0;
    unique case (phase_q)
      PH_SELECT: begin
        p1_char_d = char_e'(p1_char_sel);
        p2_char_d = char_e'(p2_char_sel);
        if (start) phase_d = PH_FIGHT;
      end
      PH_FIGHT: begin
        // The zero flags map straight onto the winner code: only P2 down is P1's win.
        if (p1_zero_next || p2_zero_next) begin
          phase_d  = PH_OVER;
          winner_d = winner_e'({p1_zero_next, p2_zero_next});
        end
      end
      PH_OVER: begin
        if (start) begin
          phase_d  = PH_SELECT;
          winner_d = WIN_NONE;
          rematch  = 1'b1;
        end
      end
      default: begin
        phase_d  = PH_SELECT;
        winner_d = WIN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q   <= PH_SELECT;
      winner_q  <= WIN_NONE;
      p1_char_q <= MAGE;
      p2_char_q <= MAGE;
    end else begin
      phase_q   <= phase_d;
      winner_q  <= winner_d;
      p1_char_q <= p1_char_d;
      p2_char_q <= p2_char_d;
    end
  end

  assign data   = pack_data(p1_char_q, p1_health, p2_char_q, p2_health);
  assign phase  = phase_q;
  assign winner = winner_q;

endmodule

// File: tb/tb_game_state_tracker.sv
// Directed vector bench for game_state_tracker with MAX_HEALTH=10 and
// COOLDOWN_CYCLES=4; each vector is one clock edge with its expected outputs.
module tb_game_state_tracker;

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        h1;
    logic [1:0]  d1;
    logic        h2;
    logic [1:0]  d2;
    logic [11:0] exp_data;
    logic [1:0]  exp_phase;
    logic [1:0]  exp_win;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  p1_char_sel, p2_char_sel;
  logic        p1_hit, p2_hit;
  logic [1:0]  p1_dmg, p2_dmg;
  logic [11:0] data;
  logic [1:0]  phase;
  logic [1:0]  winner;

  vec_t vecs[$];
  int   n_vec;
  int   n_miscomp;

  game_state_tracker #(
    .MAX_HEALTH      (10),
    .COOLDOWN_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .p1_char_sel (p1_char_sel),
    .p2_char_sel (p2_char_sel),
    .p1_hit      (p1_hit),
    .p2_hit      (p2_hit),
    .p1_dmg      (p1_dmg),
    .p2_dmg      (p2_dmg),
    .data        (data),
    .phase       (phase),
    .winner      (winner)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input int c1, input int h1, input int c2, input int h2);
    return {c1[1:0], h1[3:0], c2[1:0], h2[3:0]};
  endfunction

  task automatic add(input logic rst, input logic st, input logic [1:0] s1, input logic [1:0] s2,
                     input logic h1, input logic [1:0] d1, input logic h2, input logic [1:0] d2,
                     input logic [11:0] ed, input logic [1:0] ep, input logic [1:0] ew);
    vec_t v;
    v.rst = rst; v.start = st; v.s1 = s1; v.s2 = s2;
    v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    v.exp_data = ed; v.exp_phase = ep; v.exp_win = ew;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input logic [11:0] ed, input logic [1:0] ep, input logic [1:0] ew);
    for (int i = 0; i < n; i++) add(1, 0, 0, 0, 0, 0, 0, 0, ed, ep, ew);
  endtask

  // Driver: inputs change on the falling edge, outputs checked 1 ns after the rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; start = v.start;
    p1_char_sel = v.s1; p2_char_sel = v.s2;
    p1_hit = v.h1; p1_dmg = v.d1; p2_hit = v.h2; p2_dmg = v.d2;
    @(posedge clk);
    #1;
    n_vec++;
    if (data !== v.exp_data) begin
      n_miscomp++;
      $display("FAIL vec%0d data: got %b want %b", idx, data, v.exp_data);
    end
    if (phase !== v.exp_phase) begin
      n_miscomp++;
      $display("FAIL vec%0d phase: got %b want %b", idx, phase, v.exp_phase);
    end
    if (winner !== v.exp_win) begin
      n_miscomp++;
      $display("FAIL vec%0d winner: got %b want %b", idx, winner, v.exp_win);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic [1:0] s1, input logic [1:0] s2,
                      input logic h1, input logic [1:0] d1, input logic h2, input logic [1:0] d2,
                      input logic [11:0] ed, input logic [1:0] ep, input logic [1:0] ew, input int idx);
    vec_t v;
    v.rst = rst; v.start = st; v.s1 = s1; v.s2 = s2;
    v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    v.exp_data = ed; v.exp_phase = ep; v.exp_win = ew;
    apply(v, idx);
  endtask

  initial begin
    n_vec = 0;
    n_miscomp = 0;
    reset = 1'b0; start = 1'b0;
    p1_char_sel = 2'b00; p2_char_sel = 2'b00;
    p1_hit = 1'b0; p2_hit = 1'b0; p1_dmg = 2'b00; p2_dmg = 2'b00;

    // Reset and SELECT tracking
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 10, 0, 10), 0, 0);
    add(1, 0, 2, 1, 0, 0, 0, 0, pk(2, 10, 1, 10), 0, 0);
    add(1, 0, 2, 1, 1, 3, 0, 0, pk(2, 10, 1, 10), 0, 0);
    add(1, 1, 2, 1, 0, 0, 0, 0, pk(2, 10, 1, 10), 1, 0);
    add(1, 0, 3, 0, 0, 0, 0, 0, pk(2, 10, 1, 10), 1, 0);
    // Cooldown window: hit at k, blocked at k+2 and k+4, accepted at k+5
    add(1, 0, 0, 0, 1, 3, 0, 0, pk(2, 7, 1, 10), 1, 0);
    idle(1, pk(2, 7, 1, 10), 1, 0);
    add(1, 0, 0, 0, 1, 3, 0, 0, pk(2, 7, 1, 10), 1, 0);
    idle(1, pk(2, 7, 1, 10), 1, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0, pk(2, 7, 1, 10), 1, 0);
    add(1, 0, 0, 0, 1, 2, 0, 0, pk(2, 5, 1, 10), 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, pk(2, 5, 1, 10), 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, pk(2, 5, 1, 10), 1, 0);
    // Wear P2 down to 2, then overkill to 0: P1 wins
    add(1, 0, 0, 0, 0, 0, 1, 3, pk(2, 5, 1, 7), 1, 0);
    idle(4, pk(2, 5, 1, 7), 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 3, pk(2, 5, 1, 4), 1, 0);
    idle(4, pk(2, 5, 1, 4), 1, 0);
    add(1, 0, 0, 0, 1, 1, 1, 2, pk(2, 4, 1, 2), 1, 0);
    idle(4, pk(2, 4, 1, 2), 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 3, pk(2, 4, 1, 0), 2, 1);
    add(1, 0, 0, 3, 1, 3, 1, 1, pk(2, 4, 1, 0), 2, 1);
    add(1, 1, 0, 3, 0, 0, 0, 0, pk(2, 10, 1, 10), 0, 0);
    add(1, 0, 3, 3, 0, 0, 0, 0, pk(3, 10, 3, 10), 0, 0);
    // Draw: both players reach 0 on the same edge
    add(1, 1, 3, 3, 0, 0, 0, 0, pk(3, 10, 3, 10), 1, 0);
    add(1, 0, 0, 0, 1, 3, 1, 3, pk(3, 7, 3, 7), 1, 0);
    idle(4, pk(3, 7, 3, 7), 1, 0);
    add(1, 0, 0, 0, 1, 3, 1, 3, pk(3, 4, 3, 4), 1, 0);
    idle(4, pk(3, 4, 3, 4), 1, 0);
    add(1, 0, 0, 0, 1, 3, 1, 3, pk(3, 1, 3, 1), 1, 0);
    idle(4, pk(3, 1, 3, 1), 1, 0);
    add(1, 0, 0, 0, 1, 2, 1, 2, pk(3, 0, 3, 0), 2, 3);
    add(1, 1, 0, 0, 0, 0, 0, 0, pk(3, 10, 3, 10), 0, 0);
    // Reset mid-FIGHT with cooldown active, then a hit right after start
    add(1, 1, 1, 2, 0, 0, 0, 0, pk(1, 10, 2, 10), 1, 0);
    add(1, 0, 0, 0, 1, 3, 0, 0, pk(1, 7, 2, 10), 1, 0);
    idle(4, pk(1, 7, 2, 10), 1, 0);
    add(1, 0, 0, 0, 1, 3, 0, 0, pk(1, 4, 2, 10), 1, 0);
    add(0, 0, 0, 0, 1, 3, 0, 0, pk(0, 10, 0, 10), 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, pk(0, 10, 0, 10), 1, 0);
    add(1, 0, 0, 0, 1, 2, 0, 0, pk(0, 8, 0, 10), 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // P1 alone goes down, then start held high advances one phase per cycle
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, pk(0, 8, 0, 10), 1, 0, 100 + i);
    step(1, 0, 0, 0, 1, 3, 0, 0, pk(0, 5, 0, 10), 1, 0, 104);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, pk(0, 5, 0, 10), 1, 0, 105 + i);
    step(1, 0, 0, 0, 1, 3, 0, 0, pk(0, 2, 0, 10), 1, 0, 109);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, pk(0, 2, 0, 10), 1, 0, 110 + i);
    step(1, 0, 0, 0, 1, 3, 0, 0, pk(0, 0, 0, 10), 2, 2, 114);
    step(1, 1, 1, 1, 0, 0, 0, 0, pk(0, 10, 0, 10), 0, 0, 115);
    step(1, 1, 1, 1, 0, 0, 0, 0, pk(1, 10, 1, 10), 1, 0, 116);
    step(1, 1, 2, 2, 0, 0, 0, 0, pk(1, 10, 1, 10), 1, 0, 117);
    step(1, 0, 2, 2, 0, 0, 0, 0, pk(1, 10, 1, 10), 1, 0, 118);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
